// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus scheduler: FSM state codes,
// default timing at 50 MHz, and the commands that need the long execution wait.
package lcd_pkg;

   typedef logic [2:0] lcd_state_t;

   localparam lcd_state_t ST_IDLE   = 3'd0;
   localparam lcd_state_t ST_SETUP  = 3'd1;
   localparam lcd_state_t ST_ENABLE = 3'd2;
   localparam lcd_state_t ST_HOLD   = 3'd3;
   localparam lcd_state_t ST_EXEC   = 3'd4;

   localparam int DEF_T_AS   = 2;
   localparam int DEF_T_PW   = 25;
   localparam int DEF_T_H    = 2;
   localparam int DEF_T_EXEC = 2500;
   localparam int DEF_T_LONG = 100000;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   // Clear and return-home take ~2 ms inside the controller; data writes never do.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-request round-robin arbiter. The last-grant pointer only moves when the
// caller accepts a grant, so a grant offered in a busy cycle never counts.
module lcd_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic last;

   // On a tie the client that did not win last time goes first.
   always_comb begin
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (accept) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares one HD44780-style write bus between two byte producers, generating
// setup / enable / hold timing and the post-write execution delay.
module lcd_bus_scheduler
   import lcd_pkg::*;
#(
   parameter int T_AS   = DEF_T_AS,
   parameter int T_PW   = DEF_T_PW,
   parameter int T_H    = DEF_T_H,
   parameter int T_EXEC = DEF_T_EXEC,
   parameter int T_LONG = DEF_T_LONG
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iREQ0,
   input  logic       iREQ1,
   input  logic       iRS0,
   input  logic       iRS1,
   input  logic [7:0] iDATA0,
   input  logic [7:0] iDATA1,
   output logic       oACK0,
   output logic       oACK1,
   output logic       oBUSY,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN
);

   localparam int MAX_T = max_of(max_of(max_of(T_AS, T_PW), max_of(T_H, T_EXEC)), T_LONG);
   localparam int CNT_W = $clog2(MAX_T) + 1;

   // Each state lasts load+1 cycles, so counters are loaded with duration-1.
   localparam logic [CNT_W-1:0] LD_AS   = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LD_PW   = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] LD_H    = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0] LD_EXEC = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_LONG = CNT_W'(T_LONG - 1);

   lcd_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       data_q;
   logic             rs_q;
   logic             en_q;
   logic [1:0]       ack_q;
   logic [1:0]       gnt;
   logic             accept;
   logic             cnt_done;

   assign accept   = (state == ST_IDLE) && (gnt != 2'b00);
   assign cnt_done = (cnt == '0);

   lcd_rr_arb2 u_arb (
      .clk    (iCLK),
      .rst_n  (iRST_N),
      .req    ({iREQ1, iREQ0}),
      .accept (accept),
      .gnt    (gnt)
   );

   // Single down-counter reloaded on every state entry; the terminal count
   // advances the FSM instead of wrapping.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         data_q <= 8'h00;
         rs_q   <= 1'b0;
         en_q   <= 1'b0;
         ack_q  <= 2'b00;
      end else begin
         ack_q <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  ack_q  <= gnt;
                  rs_q   <= gnt[1] ? iRS1 : iRS0;
                  data_q <= gnt[1] ? iDATA1 : iDATA0;
                  cnt    <= LD_AS;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_done) begin
                  cnt   <= LD_PW;
                  en_q  <= 1'b1;
                  state <= ST_ENABLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ENABLE: begin
               if (cnt_done) begin
                  cnt   <= LD_H;
                  en_q  <= 1'b0;
                  state <= ST_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt_done) begin
                  cnt   <= is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
                  state <= ST_EXEC;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_EXEC: begin
               if (cnt_done) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               en_q  <= 1'b0;
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oACK0    = ack_q[0];
   assign oACK1    = ack_q[1];
   assign oBUSY    = (state != ST_IDLE);
   assign LCD_DATA = data_q;
   assign LCD_RS   = rs_q;
   assign LCD_RW   = 1'b0;
   assign LCD_EN   = en_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler using shortened timing so the long
// command path fits in a short run; expected grants are kept in a scoreboard.
module tb_lcd_bus_scheduler;

   localparam int T_AS   = 2;
   localparam int T_PW   = 5;
   localparam int T_H    = 2;
   localparam int T_EXEC = 20;
   localparam int T_LONG = 60;
   localparam int SHORT_PERIOD = 1 + T_AS + T_PW + T_H + T_EXEC;
   localparam int LONG_PERIOD  = 1 + T_AS + T_PW + T_H + T_LONG;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       rs0 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, busy, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   typedef struct {
      int         client;
      logic       rs;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   both_hi = 0;
   int   cyc = 0;

   lcd_bus_scheduler #(
      .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_EXEC(T_EXEC), .T_LONG(T_LONG)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n),
      .iREQ0(req0), .iREQ1(req1),
      .iRS0(rs0), .iRS1(rs1),
      .iDATA0(data0), .iDATA1(data1),
      .oACK0(ack0), .oACK1(ack1), .oBUSY(busy),
      .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int client, input logic rs, input logic [7:0] data, input bit push);
      exp_t e;
      if (client == 0) begin
         req0 = 1'b1; rs0 = rs; data0 = data;
      end else begin
         req1 = 1'b1; rs1 = rs; data1 = data;
      end
      if (push) begin
         e.client = client; e.rs = rs; e.data = data;
         sb_q.push_back(e);
      end
   endtask

   task automatic pushExpected(input int client, input logic rs, input logic [7:0] data);
      exp_t e;
      e.client = client; e.rs = rs; e.data = data;
      sb_q.push_back(e);
   endtask

   // Waits (bounded) for an ACK and compares it against the scoreboard head.
   task automatic serviceAck(input string tag, output int gcyc);
      exp_t e;
      int   client;
      client = -1;
      gcyc   = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ack0 && ack1) both_hi++;
         if (ack0 || ack1) begin
            client = ack1 ? 1 : 0;
            gcyc   = cyc;
            break;
         end
      end
      if (sb_q.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         checkOutput({tag, "_client"}, 32'(client), 32'(e.client));
         checkOutput({tag, "_data"}, {24'h0, lcd_data}, {24'h0, e.data});
         checkOutput({tag, "_rs"}, {31'h0, lcd_rs}, {31'h0, e.rs});
      end
   endtask

   // Starts at the negedge where ACK is visible (offset 0) and follows the
   // transfer until BUSY drops.
   task automatic measureTransfer(output int en_rise, output int en_width, output int idle_at,
                                  output int ack_cnt, output int stable);
      logic [7:0] d0;
      logic       r0;
      d0 = lcd_data; r0 = lcd_rs;
      en_rise = -1; en_width = 0; idle_at = -1; ack_cnt = 0; stable = 1;
      for (int k = 0; k < 200; k++) begin
         if (k > 0) @(negedge clk);
         if (!busy) begin
            idle_at = k;
            break;
         end
         if (lcd_en) begin
            if (en_rise < 0) en_rise = k;
            en_width++;
         end
         if (ack0 || ack1) ack_cnt++;
         if (ack0 && ack1) both_hi++;
         if (lcd_data !== d0 || lcd_rs !== r0 || lcd_rw !== 1'b0) stable = 0;
      end
   endtask

   task automatic checkTransfer(input string tag, input int exp_idle);
      int rise, width, idle, acks, stable;
      measureTransfer(rise, width, idle, acks, stable);
      checkOutput({tag, "_en_rise"}, 32'(rise), 32'(T_AS));
      checkOutput({tag, "_en_width"}, 32'(width), 32'(T_PW));
      checkOutput({tag, "_idle_at"}, 32'(idle), 32'(exp_idle));
      checkOutput({tag, "_ack_cnt"}, 32'(acks), 32'd1);
      checkOutput({tag, "_bus_stable"}, 32'(stable), 32'd1);
   endtask

   initial begin
      int g0, g1, gprev;

      // Reset and idle behaviour
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("rst_data", {24'h0, lcd_data}, 32'h0);
      checkOutput("rst_rs", {31'h0, lcd_rs}, 32'h0);
      checkOutput("rst_rw", {31'h0, lcd_rw}, 32'h0);
      checkOutput("rst_en", {31'h0, lcd_en}, 32'h0);
      checkOutput("rst_ack", {30'h0, ack1, ack0}, 32'h0);
      checkOutput("rst_busy", {31'h0, busy}, 32'h0);

      // Ordinary data write from client 0
      applyStimulus(0, 1'b1, 8'h41, 1'b1);
      serviceAck("wr41", g0);
      req0 = 1'b0;
      checkTransfer("wr41", SHORT_PERIOD - 1);

      // Clear display from client 1; client 0 request arrives while busy
      applyStimulus(1, 1'b0, 8'h01, 1'b1);
      serviceAck("clr", g0);
      req1 = 1'b0;
      applyStimulus(0, 1'b1, 8'h42, 1'b1);
      checkTransfer("clr", LONG_PERIOD - 1);
      serviceAck("after_clr", g1);
      req0 = 1'b0;
      checkOutput("long_period", 32'(g1 - g0), 32'(LONG_PERIOD));
      checkTransfer("wr42", SHORT_PERIOD - 1);

      // Both clients streaming; client 0 won last, so client 1 goes first
      pushExpected(1, 1'b1, 8'h20);
      pushExpected(0, 1'b1, 8'h10);
      pushExpected(1, 1'b1, 8'h21);
      pushExpected(0, 1'b1, 8'h11);
      applyStimulus(0, 1'b1, 8'h10, 1'b0);
      applyStimulus(1, 1'b1, 8'h20, 1'b0);
      gprev = -1;
      for (int i = 0; i < 4; i++) begin
         serviceAck($sformatf("rr%0d", i), g0);
         if (ack1) data1 = data1 + 8'h01;
         else data0 = data0 + 8'h01;
         if (i == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         if (gprev >= 0) checkOutput($sformatf("rr_period%0d", i), 32'(g0 - gprev), 32'(SHORT_PERIOD));
         gprev = g0;
      end
      checkTransfer("rr_last", SHORT_PERIOD - 1);

      // Execution wait selection
      applyStimulus(0, 1'b0, 8'h38, 1'b1);
      serviceAck("fnset", g0);
      req0 = 1'b0;
      checkTransfer("fnset", SHORT_PERIOD - 1);
      applyStimulus(1, 1'b1, 8'h01, 1'b1);
      serviceAck("data01", g0);
      req1 = 1'b0;
      checkTransfer("data01", SHORT_PERIOD - 1);
      applyStimulus(0, 1'b0, 8'h03, 1'b1);
      serviceAck("home3", g0);
      req0 = 1'b0;
      checkTransfer("home3", LONG_PERIOD - 1);

      // Reset during the enable pulse, with client 1 waiting
      applyStimulus(0, 1'b1, 8'h55, 1'b1);
      serviceAck("wr55", g0);
      req0 = 1'b0;
      applyStimulus(1, 1'b1, 8'h66, 1'b0);
      repeat (T_AS + 1) @(negedge clk);
      checkOutput("mid_en_high", {31'h0, lcd_en}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_en_low", {31'h0, lcd_en}, 32'h0);
      checkOutput("async_data", {24'h0, lcd_data}, 32'h0);
      checkOutput("async_busy", {31'h0, busy}, 32'h0);
      pushExpected(1, 1'b1, 8'h66);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      serviceAck("fresh66", g0);
      req1 = 1'b0;
      checkTransfer("fresh66", SHORT_PERIOD - 1);

      // Reset returns the pointer so client 0 wins a tie even after winning last
      applyStimulus(0, 1'b1, 8'h77, 1'b1);
      serviceAck("wr77", g0);
      req0 = 1'b0;
      checkTransfer("wr77", SHORT_PERIOD - 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 8'h88, 1'b1);
      applyStimulus(1, 1'b1, 8'h99, 1'b1);
      serviceAck("tie0", g0);
      req0 = 1'b0;
      checkTransfer("tie0", SHORT_PERIOD - 1);
      serviceAck("tie1", g1);
      req1 = 1'b0;
      checkOutput("tie_period", 32'(g1 - g0), 32'(SHORT_PERIOD));
      checkTransfer("tie1", SHORT_PERIOD - 1);

      checkOutput("never_both_ack", 32'(both_hi), 32'd0);
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
